// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan-out: pixel divider, h/v counters, one-pixel output stage, frame tick.
// Optional colour-bar generator guarded by VGA_TEST_PATTERN_EN (adds pattern_sel input).
module vga_scan_out #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [11:0] rgb_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        pixel_tick,
    output logic        frame_tick,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] vga_rgb
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } out_t;

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             hs_act;
    logic             vs_act;
    logic [11:0]      src_rgb;
    out_t             out_nxt;
    out_t             out_q;

    assign pixel_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_cnt == 10'(H_TOTAL - 1));
    assign v_last     = (v_cnt == 10'(V_TOTAL - 1));
    assign video_on   = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
    assign hs_act     = (h_cnt >= 10'(HS_START)) && (h_cnt <= 10'(HS_END));
    assign vs_act     = (v_cnt >= 10'(VS_START)) && (v_cnt <= 10'(VS_END));
    assign pixel_x    = h_cnt;
    assign pixel_y    = v_cnt;

`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] bar_rgb;

    // 128-pixel bars: index is just the top three bits of x, no divider needed.
    always_comb begin
        bar_rgb = 12'h000;
        case (h_cnt[9:7])
            3'd0:    bar_rgb = 12'hFFF;
            3'd1:    bar_rgb = 12'hFF0;
            3'd2:    bar_rgb = 12'h0FF;
            3'd3:    bar_rgb = 12'h0F0;
            3'd4:    bar_rgb = 12'hF0F;
            3'd5:    bar_rgb = 12'hF00;
            3'd6:    bar_rgb = 12'h00F;
            default: bar_rgb = 12'h000;
        endcase
    end

    assign src_rgb = pattern_sel ? bar_rgb : rgb_in;
`else
    assign src_rgb = rgb_in;
`endif

    always_comb begin
        out_nxt.hs  = !hs_act;
        out_nxt.vs  = !vs_act;
        out_nxt.rgb = video_on ? src_rgb : 12'h000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (pixel_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_tick) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Sync and colour share one register so they stay aligned, one pixel behind the counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
        end else if (pixel_tick) begin
            out_q <= out_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= pixel_tick && h_last && v_last;
        end
    end

    assign hsync   = out_q.hs;
    assign vsync   = out_q.vs;
    assign vga_rgb = out_q.rgb;
endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out on a shrunken raster (24x13 pixels, CLK_DIV=4) so full frames are cheap.
module tb_vga_scan_out;
    localparam int CD = 4;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 13
    localparam int LIMIT = 2 * HT * VT * CD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] rgb_in = 12'hABC;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, pixel_tick, frame_tick, hsync, vsync;
    logic [11:0] vga_rgb;
`ifdef VGA_TEST_PATTERN_EN
    logic        pattern_sel = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_scan_out #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
`endif
        .rgb_in     (rgb_in),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .video_on   (video_on),
        .pixel_tick (pixel_tick),
        .frame_tick (frame_tick),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_rgb    (vga_rgb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stops on the first sample after the edge that moved the counters onto (x,y).
    task automatic goto(input int x, input int y);
        int n = 0;
        while (!(pixel_x == 10'(x) && pixel_y == 10'(y)) && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) chk("goto_timeout", {22'd0, pixel_x}, 32'(x));
    endtask

    task automatic count_until(input logic want_hs, input logic use_hs, input logic lvl, output int n);
        logic s;
        n = 0;
        do begin
            step();
            n++;
            s = use_hs ? hsync : vsync;
        end while (s != lvl && n < LIMIT);
        if (want_hs) begin end
    endtask

    task automatic mid_reset(input string tag);
        int ft = 0;
        #2 reset_n = 1'b0;
        #1;
        chk({tag, "_x"},    {22'd0, pixel_x}, 0);
        chk({tag, "_y"},    {22'd0, pixel_y}, 0);
        chk({tag, "_hs"},   {31'd0, hsync}, 1);
        chk({tag, "_vs"},   {31'd0, vsync}, 1);
        chk({tag, "_rgb"},  {20'd0, vga_rgb}, 0);
        chk({tag, "_tick"}, {31'd0, pixel_tick}, 0);
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < CD; i++) begin
            step();
            if (frame_tick) ft++;
        end
        chk({tag, "_restart_x"}, {22'd0, pixel_x}, 1);
        chk({tag, "_restart_y"}, {22'd0, pixel_y}, 0);
        chk({tag, "_no_ftick"},  32'(ft), 0);
    endtask

    initial begin
        int n;
        int m;
        // Reset state
        repeat (3) step();
        chk("rst_x",     {22'd0, pixel_x}, 0);
        chk("rst_y",     {22'd0, pixel_y}, 0);
        chk("rst_tick",  {31'd0, pixel_tick}, 0);
        chk("rst_ftick", {31'd0, frame_tick}, 0);
        chk("rst_hs",    {31'd0, hsync}, 1);
        chk("rst_vs",    {31'd0, vsync}, 1);
        chk("rst_rgb",   {20'd0, vga_rgb}, 0);
        chk("rst_von",   {31'd0, video_on}, 1);

        // Release: edges 0,1 no tick, tick visible before edge 3, counters move on edge 3
        reset_n = 1'b1;
        step();
        chk("tick_e0", {31'd0, pixel_tick}, 0);
        step();
        chk("tick_e1", {31'd0, pixel_tick}, 0);
        step();
        chk("tick_e2", {31'd0, pixel_tick}, 1);
        chk("pre_tick_x",   {22'd0, pixel_x}, 0);
        chk("pre_tick_rgb", {20'd0, vga_rgb}, 0);
        chk("pre_tick_hs",  {31'd0, hsync}, 1);
        step();
        chk("first_adv_x",   {22'd0, pixel_x}, 1);
        chk("first_adv_rgb", {20'd0, vga_rgb}, 12'hABC);
        n = 0;
        do begin step(); n++; end while (!pixel_tick && n < 16);
        chk("tick_period", 32'(n), 3);

        // rgb_in only sampled on the tick edge
        goto(2, 0);
        rgb_in = 12'h123;
        step();
        step();
        chk("rgb_hold", {20'd0, vga_rgb}, 12'hABC);
        rgb_in = 12'h5A5;
        step();
        step();
        chk("rgb_sample", {20'd0, vga_rgb}, 12'h5A5);
        rgb_in = 12'hABC;

        // Horizontal blanking boundary
        goto(HA - 1, 0);
        chk("von_last", {31'd0, video_on}, 1);
        goto(HA, 0);
        chk("von_off",         {31'd0, video_on}, 0);
        chk("rgb_last_active", {20'd0, vga_rgb}, 12'hABC);
        repeat (CD) step();
        chk("rgb_hblank", {20'd0, vga_rgb}, 0);

        // hsync: falls one pixel after x=18, low for HS pixels
        goto(HA + HF, 0);
        chk("hs_pre", {31'd0, hsync}, 1);
        count_until(1'b1, 1'b1, 1'b0, n);
        chk("hs_fall_lag", 32'(n), CD);
        count_until(1'b1, 1'b1, 1'b1, m);
        chk("hs_width", 32'(m), HS * CD);

        // Line wrap
        goto(HT - 1, 0);
        repeat (CD - 1) step();
        chk("hwrap_pre", {22'd0, pixel_x}, HT - 1);
        step();
        chk("hwrap_x", {22'd0, pixel_x}, 0);
        chk("hwrap_y", {22'd0, pixel_y}, 1);

        // Vertical blanking and vsync
        goto(3, VA);
        repeat (CD) step();
        chk("vblank_rgb", {20'd0, vga_rgb}, 0);
        chk("vblank_von", {31'd0, video_on}, 0);
        goto(0, VA + VF);
        chk("vs_pre", {31'd0, vsync}, 1);
        count_until(1'b0, 1'b0, 1'b0, n);
        chk("vs_fall_lag", 32'(n), CD);
        count_until(1'b0, 1'b0, 1'b1, m);
        chk("vs_width", 32'(m), VS * HT * CD);

        // frame_tick: at (0,0), one clock wide, once per frame
        n = 0;
        while (!frame_tick && n < LIMIT) begin step(); n++; end
        chk("ftick_seen", {31'd0, frame_tick}, 1);
        chk("ftick_x", {22'd0, pixel_x}, 0);
        chk("ftick_y", {22'd0, pixel_y}, 0);
        step();
        chk("ftick_width", {31'd0, frame_tick}, 0);
        n = 1;
        while (!frame_tick && n < LIMIT) begin step(); n++; end
        chk("frame_period", 32'(n), HT * VT * CD);
        step();

        // Mid-frame resets: once in the active area, once inside both sync pulses
        goto(5, 3);
        chk("pre_rst_rgb", {20'd0, vga_rgb}, 12'hABC);
        mid_reset("mrst_a");
        goto(HA + HF + 1, VA + VF);
        chk("pre_rst_hs", {31'd0, hsync}, 0);
        chk("pre_rst_vs", {31'd0, vsync}, 0);
        mid_reset("mrst_b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
